// File: rtl/lcd12864_bus_rx.sv
// -----------------------------------------------------------------------------
// lcd12864_bus_rx
//
// Responder / monitor for an ST7920-style LCD12864 8-bit parallel write bus.
// The bus is sampled asynchronously, and each byte is decoded on the falling
// edge of the synchronised enable. The block executes the basic instruction
// set and keeps a 64-byte DDRAM shadow that a host can read back.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   lcd_rs/rw/en/dat        LCD bus inputs (asynchronous to clk)
//   wr_valid/addr/data      one-cycle strobe for each stored data byte
//   rd_addr / rd_data       host read port into the shadow RAM (1-cycle latency)
//   busy                    clear fill in progress
//   disp_on/cursor_on/
//   blink_on                display control bits
//   overrun                 sticky: a strobe arrived while busy and was dropped
//   ignored_cnt             saturating count of dropped/read/unsupported strobes
// -----------------------------------------------------------------------------
module lcd12864_bus_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_EN_HIGH = 2,
    parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_dat,
    output logic       wr_valid,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       overrun,
    output logic [7:0] ignored_cnt
);

    localparam int             CW     = (MIN_EN_HIGH < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);
    localparam logic [CW-1:0]  EN_SAT = CW'(MIN_EN_HIGH);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    // Bus synchroniser: all four inputs move together so rs/rw/dat seen at the
    // falling edge belong to the same bus cycle as that edge.
    logic [10:0] sync_q [SYNC_STAGES];

    logic       s_rs, s_rw, s_en;
    logic [7:0] s_dat;
    assign {s_rs, s_rw, s_en, s_dat} = sync_q[SYNC_STAGES-1];

    state_t        state_q, state_d;
    logic [5:0]    fill_cnt_q, fill_cnt_d;
    logic          en_prev_q;
    logic [CW-1:0] en_cnt_q, en_cnt_d;
    logic [4:0]    ac_q, ac_d;
    logic          half_q, half_d;
    logic          inc_q, inc_d;
    logic          ext_q, ext_d;
    logic          disp_q, disp_d;
    logic          cursor_q, cursor_d;
    logic          blink_q, blink_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    ign_q, ign_d;
    logic          wr_valid_q, wr_valid_d;
    logic [5:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem [64];
    logic          mem_we;
    logic [5:0]    mem_waddr;
    logic [7:0]    mem_wdata;

    logic          strobe;
    logic          ign_inc;
    logic [5:0]    ptr;
    logic [5:0]    ptr_n;

    assign ptr    = {ac_q, half_q};
    assign strobe = en_prev_q && !s_en && (en_cnt_q >= EN_SAT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        ac_d       = ac_q;
        half_d     = half_q;
        inc_d      = inc_q;
        ext_d      = ext_q;
        disp_d     = disp_q;
        cursor_d   = cursor_q;
        blink_d    = blink_q;
        overrun_d  = overrun_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        mem_waddr  = ptr;
        mem_wdata  = s_dat;
        ign_inc    = 1'b0;
        ptr_n      = inc_q ? ptr + 6'd1 : ptr - 6'd1;

        // En-high counter saturates at the acceptance threshold.
        if (!s_en)                en_cnt_d = '0;
        else if (en_cnt_q != EN_SAT) en_cnt_d = en_cnt_q + 1'b1;
        else                      en_cnt_d = en_cnt_q;

        if (state_q == S_FILL) begin
            mem_we     = 1'b1;
            mem_waddr  = fill_cnt_q;
            mem_wdata  = CLEAR_CHAR;
            fill_cnt_d = fill_cnt_q + 6'd1;
            if (fill_cnt_q == 6'd63) state_d = S_IDLE;
        end

        if (strobe) begin
            if (state_q == S_FILL) begin
                // Includes the final fill cycle: the edge is still dropped.
                overrun_d = 1'b1;
                ign_inc   = 1'b1;
            end else if (s_rw) begin
                ign_inc = 1'b1;
            end else if (s_rs) begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr;
                wr_data_d  = s_dat;
                {ac_d, half_d} = ptr_n;
            end else if (s_dat[7:4] == 4'h3) begin
                ext_d = s_dat[2];
            end else if (ext_q) begin
                ign_inc = 1'b1;
            end else if (s_dat[7]) begin
                ac_d   = s_dat[4:0];
                half_d = 1'b0;
            end else if (s_dat[6] || (s_dat[5:4] != 2'b00)) begin
                // CGRAM address, shift, and the unsupported 0x20-0x2F group.
                ign_inc = 1'b1;
            end else if (s_dat[3]) begin
                disp_d   = s_dat[2];
                cursor_d = s_dat[1];
                blink_d  = s_dat[0];
            end else if (s_dat[2]) begin
                inc_d = s_dat[1];
            end else if (s_dat[1]) begin
                ac_d   = '0;
                half_d = 1'b0;
            end else if (s_dat[0]) begin
                ac_d       = '0;
                half_d     = 1'b0;
                inc_d      = 1'b1;
                state_d    = S_FILL;
                fill_cnt_d = '0;
            end else begin
                ign_inc = 1'b1;
            end
        end

        ign_d = (ign_inc && (ign_q != 8'hFF)) ? ign_q + 8'd1 : ign_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            en_prev_q  <= 1'b0;
            en_cnt_q   <= '0;
            ac_q       <= '0;
            half_q     <= 1'b0;
            inc_q      <= 1'b1;
            ext_q      <= 1'b0;
            disp_q     <= 1'b0;
            cursor_q   <= 1'b0;
            blink_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ign_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            sync_q[0] <= {lcd_rs, lcd_rw, lcd_en, lcd_dat};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            en_prev_q  <= s_en;
            en_cnt_q   <= en_cnt_d;
            ac_q       <= ac_d;
            half_q     <= half_d;
            inc_q      <= inc_d;
            ext_q      <= ext_d;
            disp_q     <= disp_d;
            cursor_q   <= cursor_d;
            blink_q    <= blink_d;
            overrun_q  <= overrun_d;
            ign_q      <= ign_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // NOTE: the shadow RAM has no reset; only the clear command initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_data     = rd_data_q;
    assign busy        = (state_q == S_FILL);
    assign disp_on     = disp_q;
    assign cursor_on   = cursor_q;
    assign blink_on    = blink_q;
    assign overrun     = overrun_q;
    assign ignored_cnt = ign_q;

endmodule

// File: tb/tb_lcd12864_bus_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd12864_bus_rx
//
// Directed testbench for lcd12864_bus_rx. A behavioural model of the panel
// (byte pointer, flags, shadow array, expected write events with their cycle)
// is updated whenever the bench releases en; one compare process checks the
// DUT against it on every negative clock edge, and literal expectations pin
// the model at key points.
// -----------------------------------------------------------------------------
module tb_lcd12864_bus_rx;

    localparam int         SYNC_STAGES = 2;
    localparam int         MIN_EN_HIGH = 2;
    localparam logic [7:0] CLEAR_CHAR  = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, disp_on, cursor_on, blink_on, overrun;
    logic [7:0] ignored_cnt;

    lcd12864_bus_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .MIN_EN_HIGH(MIN_EN_HIGH),
        .CLEAR_CHAR (CLEAR_CHAR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .overrun(overrun), .ignored_cnt(ignored_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] m_ram [64];
    bit         m_known [64];
    int         m_ptr, m_ign, fill_lo, fill_hi, flag_ok, busy_run;
    bit         m_inc, m_ext, m_disp, m_cur, m_blink, m_ovr;

    task automatic model_reset();
        m_ptr = 0; m_inc = 1; m_ext = 0;
        m_disp = 0; m_cur = 0; m_blink = 0; m_ovr = 0; m_ign = 0;
        fill_lo = -10; fill_hi = -20; flag_ok = 0;
        wq.delete();
    endtask

    task automatic bump();
        if (m_ign < 255) m_ign++;
    endtask

    // k is the cycle in which the synchronised falling edge is seen; its
    // effects become visible one cycle later.
    task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] d,
                                input int hi, input int k);
        if (hi < MIN_EN_HIGH) return;
        if (k >= fill_lo && k <= fill_hi) begin
            m_ovr = 1; bump();
        end else if (rw) begin
            bump();
        end else if (rs) begin
            wq.push_back('{k + 1, 6'(m_ptr), d});
            m_ram[m_ptr]   = d;
            m_known[m_ptr] = 1;
            m_ptr = m_inc ? (m_ptr + 1) % 64 : (m_ptr + 63) % 64;
        end else if (d >= 8'h30 && d <= 8'h3F) begin
            m_ext = d[2];
        end else if (m_ext) begin
            bump();
        end else if (d >= 8'h80) begin
            m_ptr = 2 * (int'(d) % 32);
        end else if (d >= 8'h10) begin
            bump();
        end else if (d >= 8'h08) begin
            m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
            m_inc = d[1];
        end else if (d >= 8'h02) begin
            m_ptr = 0;
        end else if (d == 8'h01) begin
            m_ptr = 0; m_inc = 1;
            fill_lo = k + 1; fill_hi = k + 64;
            for (int i = 0; i < 64; i++) begin
                m_ram[i] = CLEAR_CHAR; m_known[i] = 1;
            end
        end else begin
            bump();
        end
        flag_ok = k + 1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            check("busy", busy, (cyc >= fill_lo && cyc <= fill_hi));
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", busy_run, 64);
                busy_run = 0;
            end
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                check("wr_valid", wr_valid, 1);
                check("wr_addr", wr_addr, wq[0].addr);
                check("wr_data", wr_data, wq[0].data);
                void'(wq.pop_front());
            end else begin
                check("wr_valid", wr_valid, 0);
                if (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
            end
            if (cyc >= flag_ok) begin
                check("disp_on", disp_on, m_disp);
                check("cursor_on", cursor_on, m_cur);
                check("blink_on", blink_on, m_blink);
                check("overrun", overrun, m_ovr);
                check("ignored_cnt", ignored_cnt, m_ign);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d,
                          input int hi, input int settle);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_dat = d; lcd_en = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_en = 1'b0;
        model_strobe(rs, rw, d, hi, cyc + SYNC_STAGES);
        repeat (settle) @(negedge clk);
    endtask

    task automatic rd_check(input logic [5:0] a);
        @(negedge clk); rd_addr = a;
        @(negedge clk);
        if (m_known[a]) check("rd_data", rd_data, m_ram[a]);
    endtask

    task automatic rd_lit(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk); rd_addr = a;
        @(negedge clk);
        check("rd_lit", rd_data, exp);
        check("model_lit", m_ram[a], exp);
    endtask

    task automatic check_zero();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {disp_on, cursor_on, blink_on, overrun}, 0);
        check("rst_ignored", ignored_cnt, 0);
    endtask

    // Called right after a negedge; holds reset for one clock.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_zero();
        if (cyc >= fill_lo && cyc <= fill_hi)
            for (int i = 0; i < 64; i++) m_known[i] = 0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        lcd_rs = 0; lcd_rw = 0; lcd_en = 0; lcd_dat = 8'h00; rd_addr = 6'd0;
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        busy_run = 0;
        model_reset();
        #1 check_zero();
        @(negedge clk); #2 rst_n = 1'b1;

        // Init sequence, clear, then two data bytes.
        strobe(0, 0, 8'h30, 3, 2);
        strobe(0, 0, 8'h0C, 3, 2);
        strobe(0, 0, 8'h06, 3, 2);
        strobe(0, 0, 8'h01, 3, 2);
        repeat (70) @(negedge clk);
        strobe(1, 0, 8'hC9, 3, 4);
        strobe(1, 0, 8'hEE, 3, 4);
        check("disp_lit", {disp_on, cursor_on, blink_on}, 3'b100);
        rd_lit(6'h00, 8'hC9);
        rd_lit(6'h01, 8'hEE);
        rd_lit(6'h02, 8'h20);

        // Line addressing.
        strobe(0, 0, 8'h90, 3, 2);
        strobe(1, 0, 8'h46, 3, 2);
        strobe(1, 0, 8'h50, 3, 2);
        strobe(0, 0, 8'h98, 3, 2);
        strobe(1, 0, 8'h47, 3, 4);
        rd_lit(6'h20, 8'h46);
        rd_lit(6'h21, 8'h50);
        rd_lit(6'h30, 8'h47);

        // Pointer wrap in both directions.
        strobe(0, 0, 8'h9F, 3, 2);
        strobe(1, 0, 8'hA1, 3, 2);
        strobe(1, 0, 8'hA2, 3, 2);
        strobe(1, 0, 8'hA3, 3, 2);
        strobe(0, 0, 8'h04, 3, 2);
        strobe(0, 0, 8'h80, 3, 2);
        strobe(1, 0, 8'hB1, 3, 2);
        strobe(1, 0, 8'hB2, 3, 4);
        rd_lit(6'h3E, 8'hA1);
        rd_lit(6'h00, 8'hB1);
        rd_lit(6'h3F, 8'hB2);

        // Extended mode, unsupported instructions and a read strobe.
        strobe(0, 0, 8'h34, 3, 2);
        strobe(0, 0, 8'h0F, 3, 2);
        strobe(0, 0, 8'h30, 3, 2);
        strobe(0, 0, 8'h00, 3, 2);
        strobe(0, 0, 8'h40, 3, 2);
        strobe(0, 0, 8'h12, 3, 2);
        strobe(1, 1, 8'h55, 3, 4);
        check("ign_lit", ignored_cnt, 5);
        check("disp_kept_lit", {disp_on, cursor_on, blink_on}, 3'b100);

        // Write during clear fill is dropped.
        @(negedge clk); pulse_reset();
        strobe(0, 0, 8'h01, 3, 2);
        strobe(1, 0, 8'h77, 3, 4);
        check("ovr_lit", overrun, 1);
        check("ign1_lit", ignored_cnt, 1);
        repeat (70) @(negedge clk);
        for (int a = 0; a < 64; a++) rd_check(6'(a));
        rd_lit(6'h3F, 8'h20);

        // Short en pulse rejected, longer one accepted.
        strobe(1, 0, 8'h55, 1, 4);
        check("glitch_ign_lit", ignored_cnt, 1);
        strobe(1, 0, 8'h66, 3, 4);
        rd_lit(6'h00, 8'h66);

        // Reset in the middle of a fill.
        strobe(0, 0, 8'h01, 3, 0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (cyc == fill_lo + 20) hit = 1;
            else @(negedge clk);
        end
        check("fill20_reached", hit, 1);
        pulse_reset();
        strobe(1, 0, 8'h5A, 3, 4);
        rd_lit(6'h00, 8'h5A);

        repeat (5) @(negedge clk);
        check("wq_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
